// File: rtl/mem_pkg.sv
// Shared types for the memory access controller: access sizes, FSM states, request payload.
// Optional build macro used by the controller: MISALIGN_TRAP_EN.
package mem_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned LANES      = DATA_WIDTH / 8;
    localparam int unsigned OFF_WIDTH  = $clog2(LANES);

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } access_sz_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RESP,
        S_RMW_RD,
        S_RMW_WR,
        S_WR
    } state_e;

    typedef struct packed {
        access_sz_e             sz;
        logic                   uns;
        logic [OFF_WIDTH-1:0]   off;
        logic [DATA_WIDTH-1:0]  wdata;
    } req_t;

    // Reserved size encoding 2'b11 behaves as a word access.
    function automatic access_sz_e decode_sz(input logic [1:0] sel);
        case (sel)
            2'b01:   return SZ_HALF;
            2'b10:   return SZ_BYTE;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input access_sz_e sz, input logic [OFF_WIDTH-1:0] off);
        case (sz)
            SZ_HALF: return off[0];
            SZ_WORD: return off != '0;
            default: return 1'b0;
        endcase
    endfunction

    // Drops address bits below the access size so the lane select is always aligned.
    function automatic logic [OFF_WIDTH-1:0] align_off(input access_sz_e sz, input logic [OFF_WIDTH-1:0] off);
        case (sz)
            SZ_WORD: return '0;
            SZ_HALF: return {off[1], 1'b0};
            default: return off;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU request/response and word-RAM signals of the memory access controller.
interface mem_access_ctrl_if;

    logic                            cpu_req;
    logic                            cpu_we;
    logic [1:0]                      cpu_sel;
    logic                            cpu_uns;
    logic [mem_pkg::ADDR_WIDTH-1:0]  cpu_addr;
    logic [mem_pkg::DATA_WIDTH-1:0]  cpu_wdata;
    logic [mem_pkg::DATA_WIDTH-1:0]  cpu_rdata;
    logic                            cpu_ready;
    logic                            cpu_err;
    logic [mem_pkg::ADDR_WIDTH-1:0]  ram_addr;
    logic [mem_pkg::DATA_WIDTH-1:0]  ram_wdata;
    logic                            ram_we;
    logic [mem_pkg::DATA_WIDTH-1:0]  ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_sel, cpu_uns, cpu_addr, cpu_wdata, ram_rdata,
        output cpu_rdata, cpu_ready, cpu_err, ram_addr, ram_wdata, ram_we
    );

    modport master (
        output cpu_req, cpu_we, cpu_sel, cpu_uns, cpu_addr, cpu_wdata, ram_rdata,
        input  cpu_rdata, cpu_ready, cpu_err, ram_addr, ram_wdata, ram_we
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane extract/extend for loads and lane merge for sub-word stores (little-endian).
module mem_lane_align
    import mem_pkg::*;
(
    input  access_sz_e             sz,
    input  logic                   uns,
    input  logic [OFF_WIDTH-1:0]   off,
    input  logic [DATA_WIDTH-1:0]  rword,
    input  logic [DATA_WIDTH-1:0]  wdata,
    output logic [DATA_WIDTH-1:0]  load_c,
    output logic [DATA_WIDTH-1:0]  merge_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = rword[{off, 3'b000} +: 8];
        half_v  = off[1] ? rword[31:16] : rword[15:0];
        load_c  = rword;
        merge_c = wdata;
        case (sz)
            SZ_BYTE: begin
                load_c  = {{24{~uns & byte_v[7]}}, byte_v};
                merge_c = rword;
                merge_c[{off, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_c  = {{16{~uns & half_v[15]}}, half_v};
                merge_c = off[1] ? {wdata[15:0], rword[15:0]} : {rword[31:16], wdata[15:0]};
            end
            default: begin
                load_c  = rword;
                merge_c = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences CPU loads/stores onto a word-wide RAM with sub-word read-modify-write.
// Build option: define MISALIGN_TRAP_EN to complete misaligned accesses with cpu_err.
module mem_access_ctrl
    import mem_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    mem_access_ctrl_if.slave bus
);

    state_e                  state;
    req_t                    req;
    state_e                  accept_next_c;
    access_sz_e              sz_in;
    logic [OFF_WIDTH-1:0]    off_in;
    logic                    accept_c;
    logic [DATA_WIDTH-1:0]   load_c;
    logic [DATA_WIDTH-1:0]   merge_c;

    assign sz_in  = decode_sz(bus.cpu_sel);
    assign off_in = bus.cpu_addr[OFF_WIDTH-1:0];
    // The cycle carrying a completion pulse never accepts a new request.
    assign accept_c = (state == S_IDLE) && bus.cpu_req && !bus.cpu_ready;

`ifdef MISALIGN_TRAP_EN
    logic err_q;
    logic misalign_c;
    assign misalign_c = is_misaligned(sz_in, off_in);
`else
    assign bus.cpu_err = 1'b0;
`endif

    always_comb begin
        accept_next_c = S_RD;
        if (bus.cpu_we) begin
            accept_next_c = (sz_in == SZ_WORD) ? S_WR : S_RMW_RD;
        end
`ifdef MISALIGN_TRAP_EN
        if (misalign_c) begin
            accept_next_c = S_WR;
        end
`endif
    end

    mem_lane_align u_align (
        .sz      (req.sz),
        .uns     (req.uns),
        .off     (req.off),
        .rword   (bus.ram_rdata),
        .wdata   (req.wdata),
        .load_c  (load_c),
        .merge_c (merge_c)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= S_IDLE;
            req           <= '0;
            bus.cpu_rdata <= '0;
            bus.cpu_ready <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.ram_we    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            err_q         <= 1'b0;
            bus.cpu_err   <= 1'b0;
`endif
        end else begin
            bus.cpu_ready <= 1'b0;
            bus.ram_we    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            bus.cpu_err   <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        req <= '{sz: sz_in, uns: bus.cpu_uns,
                                 off: align_off(sz_in, off_in), wdata: bus.cpu_wdata};
                        bus.ram_addr <= {bus.cpu_addr[ADDR_WIDTH-1:OFF_WIDTH], OFF_WIDTH'(0)};
                        state        <= accept_next_c;
`ifdef MISALIGN_TRAP_EN
                        err_q        <= misalign_c;
`endif
                    end
                end
                S_RD:     state <= S_RESP;
                S_RESP: begin
                    bus.cpu_rdata <= load_c;
                    bus.cpu_ready <= 1'b1;
                    state         <= S_IDLE;
                end
                S_RMW_RD: state <= S_RMW_WR;
                S_RMW_WR: begin
                    bus.ram_wdata <= merge_c;
                    bus.ram_we    <= 1'b1;
                    bus.cpu_ready <= 1'b1;
                    state         <= S_IDLE;
                end
                S_WR: begin
                    bus.cpu_ready <= 1'b1;
                    state         <= S_IDLE;
`ifdef MISALIGN_TRAP_EN
                    bus.cpu_err   <= err_q;
                    if (!err_q) begin
                        bus.ram_wdata <= req.wdata;
                        bus.ram_we    <= 1'b1;
                    end
`else
                    bus.ram_wdata <= req.wdata;
                    bus.ram_we    <= 1'b1;
`endif
                end
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a registered-read word RAM model.
module tb_mem_access_ctrl;

    localparam logic [1:0] SEL_W = 2'b00;
    localparam logic [1:0] SEL_H = 2'b01;
    localparam logic [1:0] SEL_B = 2'b10;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ram     [1024];
    logic [31:0] ref_mem [1024];
    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          rdy_cnt = 0;
    int          we_cnt = 0;
    logic        prev_rdy = 1'b0;
    logic [31:0] last_load = '0;

    always #5 clk = ~clk;

    mem_access_ctrl_if bus ();

    mem_access_ctrl dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // Word RAM: data for an address appears the cycle after it is presented.
    always @(posedge clk) begin
        if (bus.ram_we) ram[bus.ram_addr[11:2]] <= bus.ram_wdata;
        bus.ram_rdata <= ram[bus.ram_addr[11:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic misaligned(input logic [1:0] sel, input logic [1:0] a);
        if (sel == SEL_H) return a[0];
        if (sel == SEL_B) return 1'b0;
        return a != 2'b00;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sel,
                                             input logic uns, input logic [1:0] a);
        logic [31:0] sh;
        if (sel == SEL_B) begin
            sh = w >> {a, 3'b000};
            return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        end
        if (sel == SEL_H) begin
            sh = w >> {a[1], 4'b0000};
            return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        end
        return w;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sel, input logic [1:0] a);
        logic [31:0] mask;
        logic [4:0]  shamt;
        if (sel == SEL_B) begin
            shamt = {a, 3'b000};
            mask  = 32'h0000_00FF << shamt;
        end else if (sel == SEL_H) begin
            shamt = {a[1], 4'b0000};
            mask  = 32'h0000_FFFF << shamt;
        end else begin
            shamt = 5'd0;
            mask  = 32'hFFFF_FFFF;
        end
        return (old & ~mask) | ((wd << shamt) & mask);
    endfunction

    // Pops one expectation per completion pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_rdy = 1'b0;
        end else begin
            if (bus.ram_we) we_cnt++;
            if (bus.cpu_ready) begin
                rdy_cnt++;
                check("ready_two_cycles", 32'(prev_rdy), 32'd0);
                if (sb.size() == 0) begin
                    check("ready_unexpected", 32'(bus.cpu_ready), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.tag, "_rdata"}, bus.cpu_rdata, e.rdata);
                    check({e.tag, "_err"}, 32'(bus.cpu_err), 32'(e.err));
                end
            end
            prev_rdy = bus.cpu_ready;
        end
    end

    // Builds the expectation for one access and updates the reference memory.
    function automatic exp_t predict(input logic we, input logic [1:0] sel, input logic uns,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input string tag, output int lat);
        exp_t        e;
        logic [9:0]  idx;
        idx   = addr[11:2];
        e.tag = tag;
        e.err = TRAP && misaligned(sel, addr[1:0]);
        if (e.err) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            last_load = ref_load(ref_mem[idx], sel, uns, addr[1:0]);
        end else begin
            lat = (sel == SEL_H || sel == SEL_B) ? 2 : 1;
            ref_mem[idx] = ref_merge(ref_mem[idx], wdata, sel, addr[1:0]);
        end
        e.rdata = last_load;
        return e;
    endfunction

    task automatic do_access(input logic we, input logic [1:0] sel, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        exp_t       e;
        int         lat;
        int         cnt;
        int         we0;
        logic [9:0] idx;
        idx = addr[11:2];
        e   = predict(we, sel, uns, addr, wdata, tag, lat);
        sb.push_back(e);
        @(negedge clk);
        we0           = we_cnt;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_sel   = sel;
        bus.cpu_uns   = uns;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!bus.cpu_ready && cnt < 20);
        bus.cpu_req = 1'b0;
        check({tag, "_ready_seen"}, 32'(bus.cpu_ready), 32'd1);
        check({tag, "_latency"}, 32'(cnt - 1), 32'(lat));
        if (!e.err) check({tag, "_ram_addr"}, bus.ram_addr, {addr[31:2], 2'b00});
        @(negedge clk);
        check({tag, "_we_count"}, 32'(we_cnt - we0), (we && !e.err) ? 32'd1 : 32'd0);
        if (we && !e.err) check({tag, "_ram_word"}, ram[idx], ref_mem[idx]);
    endtask

    initial begin
        int          we0;
        int          r0;
        int          cnt;
        exp_t        e;
        int          lat;
        logic [31:0] b2b_addr [3];

        for (int i = 0; i < 1024; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        ram[10'h080]     = 32'h1234_5678;
        ref_mem[10'h080] = 32'h1234_5678;
        ram[10'h041]     = 32'h0BAD_F00D;
        ref_mem[10'h041] = 32'h0BAD_F00D;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_sel   = SEL_W;
        bus.cpu_uns   = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;

        repeat (3) @(negedge clk);
        check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        check("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
        check("rst_cpu_err", 32'(bus.cpu_err), 32'd0);
        check("rst_ram_addr", bus.ram_addr, 32'd0);
        check("rst_ram_wdata", bus.ram_wdata, 32'd0);
        check("rst_ram_we", 32'(bus.ram_we), 32'd0);
        rst = 1'b0;

        // Reset two cycles into a load: the access is dropped.
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h0000_0200;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        we0 = we_cnt;
        r0  = rdy_cnt;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_cpu_rdata", bus.cpu_rdata, 32'd0);
        check("midrst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
        check("midrst_ram_addr", bus.ram_addr, 32'd0);
        check("midrst_ram_we", 32'(bus.ram_we), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_no_ready", 32'(rdy_cnt - r0), 32'd0);
        check("midrst_no_write", 32'(we_cnt - we0), 32'd0);
        do_access(1'b0, SEL_W, 1'b0, 32'h0000_0200, '0, "post_rst_load");

        do_access(1'b1, SEL_W, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, "st_word");
        do_access(1'b0, SEL_W, 1'b0, 32'h0000_0100, '0, "ld_word");

        do_access(1'b1, SEL_W, 1'b0, 32'h0000_0100, 32'h1122_3344, "st_base");
        do_access(1'b1, SEL_B, 1'b0, 32'h0000_0101, 32'h0000_00AA, "st_byte");
        do_access(1'b0, SEL_B, 1'b0, 32'h0000_0101, '0, "ld_byte_s");
        do_access(1'b0, SEL_B, 1'b1, 32'h0000_0101, '0, "ld_byte_u");
        do_access(1'b0, SEL_B, 1'b1, 32'h0000_0103, '0, "ld_byte_u3");

        do_access(1'b1, SEL_W, 1'b0, 32'h0000_0100, 32'h0000_0000, "st_zero");
        do_access(1'b1, SEL_H, 1'b0, 32'h0000_0102, 32'hFFFF_8001, "st_half");
        do_access(1'b0, SEL_H, 1'b0, 32'h0000_0102, '0, "ld_half_s");
        do_access(1'b0, SEL_H, 1'b1, 32'h0000_0102, '0, "ld_half_u");
        do_access(1'b0, SEL_H, 1'b0, 32'h0000_0100, '0, "ld_half_lo");

        do_access(1'b0, SEL_W, 1'b0, 32'h0000_0103, '0, "ld_word_mis");
        do_access(1'b1, SEL_H, 1'b0, 32'h0000_0105, 32'h0000_7777, "st_half_mis");
        do_access(1'b0, 2'b11, 1'b0, 32'h0000_0104, '0, "ld_rsvd_sel");

        do_access(1'b1, SEL_W, 1'b0, 32'hFFFF_FFFC, 32'hCAFE_F00D, "st_wrap");
        do_access(1'b0, SEL_W, 1'b0, 32'hFFFF_FFFC, '0, "ld_wrap");

        // Three loads with cpu_req held high throughout.
        b2b_addr[0] = 32'h0000_0200;
        b2b_addr[1] = 32'h0000_0100;
        b2b_addr[2] = 32'h0000_0104;
        for (int k = 0; k < 3; k++) begin
            e = predict(1'b0, SEL_W, 1'b0, b2b_addr[k], '0, $sformatf("b2b%0d", k), lat);
            sb.push_back(e);
        end
        r0 = rdy_cnt;
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_sel  = SEL_W;
        bus.cpu_addr = b2b_addr[0];
        for (int k = 0; k < 3; k++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (!bus.cpu_ready && cnt < 20);
            check($sformatf("b2b%0d_latency", k), 32'(cnt - 1), (k == 0) ? 32'd2 : 32'd3);
            if (k < 2) bus.cpu_addr = b2b_addr[k + 1];
            else       bus.cpu_req  = 1'b0;
        end
        repeat (6) @(negedge clk);
        check("b2b_ready_count", 32'(rdy_cnt - r0), 32'd3);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
